// File: rtl/mtx_pkg.sv
// Shared types and helpers for the element-serial matrix operations.
// Widths are fixed here: 5x5 signed 8-bit elements packed row-major into 200 bits.
package mtx_pkg;

    localparam int ELEM_W   = 8;
    localparam int MAX_DIM  = 5;
    localparam int MATRIX_W = MAX_DIM * MAX_DIM * ELEM_W;

    // 2-bit size code: 00=2x2, 01=3x3, 10=4x4, 11=5x5
    typedef logic [1:0] size_code_t;

    // Row/col counters and dimensions need 3 bits (up to 5)
    typedef logic [2:0] dim_t;

    // Flat element index, 0..24
    typedef logic [4:0] elem_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic dim_t size_to_dim(input size_code_t code);
        return dim_t'(code) + dim_t'(2);
    endfunction

    function automatic elem_idx_t idx(input dim_t r, input dim_t c);
        return elem_idx_t'(r) * elem_idx_t'(MAX_DIM) + elem_idx_t'(c);
    endfunction

endpackage

// File: rtl/mtx_idx_walker.sv
// Row/column walker for element-serial matrix operations. Visits an n x n
// region in row-major order, one element per advance, and flags the last one.
module mtx_idx_walker
    import mtx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    input  logic advance,
    input  dim_t n,
    output dim_t row,
    output dim_t col,
    output logic last
);

    logic col_wrap;

    assign col_wrap = (col == n - dim_t'(1));
    assign last     = col_wrap && (row == n - dim_t'(1));

    // Counters restart on start/clear and step row-major on advance, returning to (0,0) after the last element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (start || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col <= '0;
                row <= last ? dim_t'(0) : row + dim_t'(1);
            end else begin
                col <= col + dim_t'(1);
            end
        end
    end

endmodule

// File: rtl/mtx_transpose_seq.sv
// Sequential matrix transpose: accepts a packed matrix, copies one element per
// clock from (r,c) to (c,r) across the active n x n region, then holds the
// result until the consumer takes it. Optional symmetry detection is enabled
// with the MTX_TRANSPOSE_SYM_CHECK_EN macro (adds the sym_flag output).
module mtx_transpose_seq
    import mtx_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MATRIX_W-1:0] matrix_in,
    input  logic [1:0]          matrix_size,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MATRIX_W-1:0] matrix_out,
    output logic                busy
`ifdef MTX_TRANSPOSE_SYM_CHECK_EN
    ,
    output logic                sym_flag
`endif
);

    state_t              state;
    state_t              state_next;
    logic [MATRIX_W-1:0] src_reg;
    logic [MATRIX_W-1:0] matrix_out_q;
    dim_t                n_reg;
    dim_t                row;
    dim_t                col;
    logic                walk_last;
    logic                accept;
    logic                cancel;
    logic                running;
    elem_idx_t           rd_idx;
    elem_idx_t           wr_idx;
    logic [7:0]          rd_lsb;
    logic [7:0]          wr_lsb;
    logic [ELEM_W-1:0]   rd_elem;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    assign running    = (state == RUN);
    assign cancel     = abort && (state != IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign matrix_out = matrix_out_q;

    // Source element (row,col) lands at destination (col,row); the destination
    // offset doubles as the mirror-element offset in the source for symmetry checks.
    assign rd_idx  = idx(row, col);
    assign wr_idx  = idx(col, row);
    assign rd_lsb  = 8'(rd_idx) * 8'(ELEM_W);
    assign wr_lsb  = 8'(wr_idx) * 8'(ELEM_W);
    assign rd_elem = src_reg[rd_lsb +: ELEM_W];

    mtx_idx_walker u_walker (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .clear   (cancel),
        .advance (running),
        .n       (n_reg),
        .row     (row),
        .col     (col),
        .last    (walk_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: abort wins over completion and over the output handshake
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (walk_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the command, clear the result on accept/abort, and write one transposed element per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg      <= '0;
            n_reg        <= '0;
            matrix_out_q <= '0;
        end else if (accept) begin
            src_reg      <= matrix_in;
            n_reg        <= size_to_dim(matrix_size);
            matrix_out_q <= '0;
        end else if (cancel) begin
            matrix_out_q <= '0;
        end else if (running) begin
            matrix_out_q[wr_lsb +: ELEM_W] <= rd_elem;
        end
    end

`ifdef MTX_TRANSPOSE_SYM_CHECK_EN
    logic              sym_q;
    logic [ELEM_W-1:0] mirror_elem;

    assign mirror_elem = src_reg[wr_lsb +: ELEM_W];
    assign sym_flag    = sym_q;

    // Assume symmetric on accept; any visited element that differs from its mirror clears the flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_q <= 1'b0;
        end else if (accept) begin
            sym_q <= 1'b1;
        end else if (cancel) begin
            sym_q <= 1'b0;
        end else if (running && (rd_elem != mirror_elem)) begin
            sym_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mtx_transpose_seq.sv
// Self-checking bench for mtx_transpose_seq. Expected results come from a
// plain array transpose of the stimulus matrix restricted to the n x n region.
module tb_mtx_transpose_seq;
    import mtx_pkg::*;

    typedef int mat_t [5][5];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] matrix_in;
    logic [1:0]   matrix_size;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [199:0] matrix_out;
    logic         busy;
`ifdef MTX_TRANSPOSE_SYM_CHECK_EN
    logic         sym_flag;
`endif

    int checks = 0;
    int errors = 0;

    mtx_transpose_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .matrix_in   (matrix_in),
        .matrix_size (matrix_size),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .matrix_out  (matrix_out),
        .busy        (busy)
`ifdef MTX_TRANSPOSE_SYM_CHECK_EN
        ,
        .sym_flag    (sym_flag)
`endif
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    function automatic logic [199:0] packMat(input mat_t m);
        logic [199:0] v;
        v = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                v[(r*5+c)*8 +: 8] = m[r][c][7:0];
            end
        end
        return v;
    endfunction

    function automatic logic [199:0] expectedTranspose(input mat_t m, input int n);
        mat_t t;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                t[r][c] = 0;
            end
        end
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                t[c][r] = m[r][c];
            end
        end
        return packMat(t);
    endfunction

    function automatic logic expectedSym(input mat_t m, input int n);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                if (m[r][c][7:0] != m[c][r][7:0]) begin
                    return 1'b0;
                end
            end
        end
        return 1'b1;
    endfunction

    task automatic randomMat(output mat_t m);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                m[r][c] = int'($urandom_range(0, 255)) - 128;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge, wait (bounded) for in_ready, let the accept edge pass
    task automatic applyStimulus(input mat_t m, input logic [1:0] code, input bit holdValid);
        int k;
        k = 0;
        matrix_in   = packMat(m);
        matrix_size = code;
        in_valid    = 1'b1;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        if (!holdValid) begin
            in_valid = 1'b0;
        end
    endtask

    // Count negedge samples after the accept edge until out_valid, bounded
    task automatic waitForValid(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 60);
    endtask

    // Take the result; one cycle later the block must be idle and ready again
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_valid_drop"}, out_valid, 0);
        checkOutput({tag, "_ready_back"}, in_ready, 1);
        checkOutput({tag, "_idle"}, busy, 0);
    endtask

    // Check latency and result of an accepted command, stall the consumer, then hand off
    task automatic finishCommand(input mat_t m, input int n, input int stall, input string tag);
        int cnt;
        logic [199:0] expMat;
        expMat = expectedTranspose(m, n);
        waitForValid(cnt);
        checkOutput({tag, "_latency"}, cnt, n*n + 1);
        checkOutput({tag, "_matrix"}, matrix_out, expMat);
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_in_ready_low"}, in_ready, 0);
`ifdef MTX_TRANSPOSE_SYM_CHECK_EN
        checkOutput({tag, "_sym"}, sym_flag, expectedSym(m, n));
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, out_valid, 1);
            checkOutput({tag, "_hold_matrix"}, matrix_out, expMat);
        end
        handshake(tag);
    endtask

    task automatic runCommand(input mat_t m, input logic [1:0] code, input int stall, input string tag);
        applyStimulus(m, code, 1'b0);
        finishCommand(m, int'(code) + 2, stall, tag);
    endtask

    initial begin
        mat_t m;
        mat_t m2;
        int   pulses;
        int   cnt;
        logic [1:0] code;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        matrix_in   = '0;
        matrix_size = 2'b00;
        abort       = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_matrix", matrix_out, '0);
`ifdef MTX_TRANSPOSE_SYM_CHECK_EN
        checkOutput("reset_sym", sym_flag, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 2x2 [[1,2],[3,4]] with random data outside the active region
        $display("[TB] 2x2 directed transpose");
        randomMat(m);
        m[0][0] = 1; m[0][1] = 2; m[1][0] = 3; m[1][1] = 4;
        runCommand(m, 2'b00, 0, "t2x2");

        // 5x5 ramp with -128 at (0,4); in_valid stays high through RUN with a different command
        $display("[TB] 5x5 directed transpose, in_valid held");
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                m[r][c] = r*5 + c;
            end
        end
        m[0][4] = -128;
        applyStimulus(m, 2'b11, 1'b1);
        randomMat(m2);
        matrix_in   = packMat(m2);
        matrix_size = 2'b00;
        waitForValid(cnt);
        checkOutput("t5x5_latency", cnt, 26);
        checkOutput("t5x5_matrix", matrix_out, expectedTranspose(m, 5));
        checkOutput("t5x5_elem40", matrix_out[(4*5+0)*8 +: 8], 8'h80);
        in_valid = 1'b0;
        handshake("t5x5");

        // Backpressure: 3x3 result held for 20 cycles
        $display("[TB] 3x3 backpressure");
        randomMat(m);
        runCommand(m, 2'b01, 20, "bp3x3");

        // Abort in the 7th RUN cycle of a 4x4 command
        $display("[TB] 4x4 abort");
        randomMat(m);
        applyStimulus(m, 2'b10, 1'b0);
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_matrix", matrix_out, '0);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checkOutput("abort_no_valid", pulses, 0);

        // Abort while idle is ignored and the coincident command is accepted
        $display("[TB] idle abort with command");
        randomMat(m);
        abort = 1'b1;
        applyStimulus(m, 2'b00, 1'b0);
        abort = 1'b0;
        finishCommand(m, 2, 0, "idle_abort");

        // Randomized commands with random consumer stalls
        $display("[TB] randomized commands");
        for (int i = 0; i < 10; i++) begin
            randomMat(m);
            code = 2'($urandom_range(0, 3));
            runCommand(m, code, int'($urandom_range(0, 3)), "rand");
        end

`ifdef MTX_TRANSPOSE_SYM_CHECK_EN
        // Symmetry detection
        $display("[TB] symmetry flag");
        randomMat(m);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                m[r][c] = (r == c) ? 1 : 0;
            end
        end
        applyStimulus(m, 2'b01, 1'b0);
        waitForValid(cnt);
        checkOutput("sym_identity", sym_flag, 1);
        handshake("sym_identity");
        m[0][2] = 5;
        m[2][0] = 0;
        applyStimulus(m, 2'b01, 1'b0);
        waitForValid(cnt);
        checkOutput("sym_broken", sym_flag, 0);
        handshake("sym_broken");
`endif

        // Reset in the middle of a 5x5 RUN
        $display("[TB] reset mid-RUN");
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                m[r][c] = r*5 + c + 1;
            end
        end
        applyStimulus(m, 2'b11, 1'b0);
        repeat (9) @(negedge clk);
        checkOutput("midrun_partial", matrix_out != '0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_out_valid", out_valid, 0);
        checkOutput("midrun_rst_matrix", matrix_out, '0);
        checkOutput("midrun_rst_in_ready", in_ready, 1);
        checkOutput("midrun_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal operation resumes after reset
        randomMat(m);
        runCommand(m, 2'b10, 1, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
